nic_dma_wb_arbiter: RTL and testbench
=====================================

// Module: nic_dma_wb_arbiter
//
// PURPOSE
// Shares the NIC's single pipelined-Wishbone DMA/buffer slave port among
// g_NUM_MASTERS requesters (host bridge, TX fetch, RX store engines).
// Round-robin grant per Wishbone cycle; grant held until CYC drops and all
// acks return; per-grant watchdog frees the port from a hung slave.
// Sits between requesters and wrsw_nic dma_* port, clk_sys domain.
//
// PARAMETERS
// g_NUM_MASTERS     2    number of requesters (1..8)
// g_MAX_OUTSTANDING 4    max accepted-but-unacked strobes (power of 2)
// g_TIMEOUT         1024 cycles w/o ack while outstanding>0 before abort
//
// PORTS
// clk_sys_i   in   1    system clock; only clock
// rst_i       in   1    synchronous, active-high reset
// m_cyc_i     in   N    per-master CYC
// m_stb_i     in   N    per-master STB
// m_we_i      in   N    per-master WE
// m_sel_i     in   4N   per-master SEL, master k at [4k+3:4k]
// m_adr_i     in   32N  per-master address, master k at [32k+31:32k]
// m_dat_i     in   32N  per-master write data, same packing
// m_dat_o     out  32   read data, broadcast (valid with own m_ack_o)
// m_ack_o     out  N    per-master ACK
// m_stall_o   out  N    per-master STALL
// s_cyc_o/s_stb_o/s_we_o out 1; s_sel_o out 4; s_adr_o/s_dat_o out 32
// s_dat_i     in   32   slave read data
// s_ack_i     in   1    slave ACK
// s_stall_i   in   1    slave STALL
// grant_o     out  N    one-hot current grant (0 when idle)
// timeout_o   out  1    1-cycle pulse on watchdog abort
//
// BEHAVIOUR
// - Reset (rst_i high at edge): state IDLE, grant 0, rr pointer to master 0,
//   outstanding=0, watchdog=0; outputs: s_cyc_o=s_stb_o=0, m_ack_o=0,
//   m_stall_o=all 1, grant_o=0, timeout_o=0. Reset mid-transfer drops slave
//   CYC next edge; in-flight acks are discarded.
// - IDLE: m_stall_o all 1. If any m_cyc_i: pick first requester at or after
//   rr pointer (wrapping); register grant, go GRANT next edge. No pick: stay.
// - GRANT: s_* = granted master's signals (combinational mux from grant reg);
//   m_stall_o[g]=s_stall_i|cnt_full, others 1. s_stb_o=m_stb_i[g]&~cnt_full.
//   m_ack_o[g]=s_ack_i, others 0; m_dat_o=s_dat_i. First strobe reaches slave
//   1 cycle after CYC asserted in IDLE.
// - Outstanding count: +1 on s_stb_o&~s_stall_i, -1 on s_ack_i, both -> hold.
//   cnt_full = (count==g_MAX_OUTSTANDING). Ack with count 0 ignored (no wrap).
// - Master drops CYC with count>0: DRAIN; s_cyc_o held 1, s_stb_o=0,
//   acks still routed to master g until count=0.
// - Release: in GRANT with m_cyc_i[g]=0 and count=0, or DRAIN reaching 0:
//   s_cyc_o=0 that cycle, state IDLE, rr pointer <= g+1 mod N. Earliest
//   re-grant is next cycle; an idle cycle always separates two grants.
// - Watchdog: counts while count>0 and no s_ack_i, clears on ack. At
//   g_TIMEOUT: timeout_o pulses, count cleared, s_cyc_o=0, state IDLE,
//   pointer advances; master g sees stall=1 and must retry.
// - N=1: arbitration trivial, same timing (no bypass of IDLE cycle).
//
// STRUCTURE
// - Package nic_wb_arb_pkg: t_arb_state enum {IDLE, GRANT, DRAIN},
//   c_WB_ADR_W=32, c_WB_DAT_W=32, c_WB_SEL_W=4.
// - Sub-module nic_rr_arbiter: combinational round-robin pick from
//   req[N-1:0] and pointer -> one-hot grant + valid.
// - Top: FSM, grant/pointer regs, outstanding + watchdog counters, muxes.
//
// TESTING
// 1 Reset, M0 writes 0x0->0xDEADBEEF, 0x4->0xCAFEBABE, reads both -> slave
//   sees 2 W + 2 R in order, M0 reads back same data, grant_o=01.
// 2 M0,M1 raise CYC same cycle, pointer 0 -> M0 first; after M0 release M1
//   granted with 1 idle cycle between; then M0 re-request loses to pointer.
// 3 Slave delays acks; M0 issues 6 strobes back-to-back, max 4 -> m_stall_o
//   rises after 4th accept; count never exceeds 4; all 6 acks returned.
// 4 M0 drops CYC with 2 acks pending -> s_cyc_o stays 1, s_stb_o 0, both
//   acks reach M0, then s_cyc_o=0 and M1 granted.
// 5 Slave never acks, g_TIMEOUT=16 -> timeout_o pulses 16 cycles after last
//   accept, s_cyc_o=0, grant moves to M1.
// 6 rst_i asserted mid-burst -> next edge s_cyc_o=0, m_stall_o=all 1,
//   grant_o=0; late s_ack_i does not reach any master.

Source files
------------

// File: rtl/nic_wb_arb_pkg.sv
// Shared types and bus widths for the NIC DMA Wishbone arbiter.
package nic_wb_arb_pkg;

   localparam int unsigned c_WB_ADR_W = 32;
   localparam int unsigned c_WB_DAT_W = 32;
   localparam int unsigned c_WB_SEL_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      DRAIN
   } t_arb_state;

endpackage

// File: rtl/nic_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module nic_rr_arbiter #(
   parameter int unsigned g_N     = 2,
   parameter int unsigned g_PTR_W = 1
) (
   input  logic [g_N-1:0]     req_i,
   input  logic [g_PTR_W-1:0] ptr_i,
   output logic [g_N-1:0]     gnt_o,
   output logic               valid_o
);

   logic [g_N-1:0] req_hi;
   logic [g_N-1:0] sel_req;

   // Prefer requesters at or above the pointer; fall back to the lowest one.
   always_comb begin
      req_hi  = '0;
      gnt_o   = '0;
      valid_o = 1'b0;
      for (int i = 0; i < int'(g_N); i++) begin
         req_hi[i] = req_i[i] && (i >= int'(ptr_i));
      end
      sel_req = (|req_hi) ? req_hi : req_i;
      for (int i = 0; i < int'(g_N); i++) begin
         if (!valid_o && sel_req[i]) begin
            gnt_o[i] = 1'b1;
            valid_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/nic_dma_wb_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave among several
// masters. A grant lasts for a whole Wishbone cycle plus its outstanding acks;
// a watchdog releases the port if the slave stops acknowledging.
module nic_dma_wb_arbiter
   import nic_wb_arb_pkg::*;
#(
   parameter int unsigned g_NUM_MASTERS     = 2,
   parameter int unsigned g_MAX_OUTSTANDING = 4,
   parameter int unsigned g_TIMEOUT         = 1024
) (
   input  logic                                  clk_sys_i,
   input  logic                                  rst_i,
   input  logic [g_NUM_MASTERS-1:0]              m_cyc_i,
   input  logic [g_NUM_MASTERS-1:0]              m_stb_i,
   input  logic [g_NUM_MASTERS-1:0]              m_we_i,
   input  logic [c_WB_SEL_W*g_NUM_MASTERS-1:0]   m_sel_i,
   input  logic [c_WB_ADR_W*g_NUM_MASTERS-1:0]   m_adr_i,
   input  logic [c_WB_DAT_W*g_NUM_MASTERS-1:0]   m_dat_i,
   output logic [c_WB_DAT_W-1:0]                 m_dat_o,
   output logic [g_NUM_MASTERS-1:0]              m_ack_o,
   output logic [g_NUM_MASTERS-1:0]              m_stall_o,
   output logic                                  s_cyc_o,
   output logic                                  s_stb_o,
   output logic                                  s_we_o,
   output logic [c_WB_SEL_W-1:0]                 s_sel_o,
   output logic [c_WB_ADR_W-1:0]                 s_adr_o,
   output logic [c_WB_DAT_W-1:0]                 s_dat_o,
   input  logic [c_WB_DAT_W-1:0]                 s_dat_i,
   input  logic                                  s_ack_i,
   input  logic                                  s_stall_i,
   output logic [g_NUM_MASTERS-1:0]              grant_o,
   output logic                                  timeout_o
);

   localparam int unsigned c_N     = g_NUM_MASTERS;
   localparam int unsigned c_PTR_W = (c_N > 1) ? $clog2(c_N) : 1;
   localparam int unsigned c_CNT_W = $clog2(g_MAX_OUTSTANDING + 1);
   localparam int unsigned c_WD_W  = $clog2(g_TIMEOUT + 1);
   localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(c_N - 1);

   t_arb_state          state_q, state_d;
   logic [c_N-1:0]      grant_q, grant_d;
   logic [c_PTR_W-1:0]  ptr_q, ptr_d;
   logic [c_CNT_W-1:0]  cnt_q, cnt_d;
   logic [c_WD_W-1:0]   wdog_q, wdog_d;

   logic [c_N-1:0]      arb_gnt;
   logic                arb_valid;
   logic [c_PTR_W-1:0]  g_idx;
   logic [c_PTR_W-1:0]  ptr_next;
   logic                g_cyc;
   logic                g_stb;
   logic                cnt_full;
   logic                wd_expire;
   logic                accept;
   logic                ack_dec;
   logic                mux_we;
   logic [c_WB_SEL_W-1:0] mux_sel;
   logic [c_WB_ADR_W-1:0] mux_adr;
   logic [c_WB_DAT_W-1:0] mux_dat;

   nic_rr_arbiter #(
      .g_N     (c_N),
      .g_PTR_W (c_PTR_W)
   ) u_rr (
      .req_i   (m_cyc_i),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .valid_o (arb_valid)
   );

   // Select the granted master's bus signals and index from the grant register.
   always_comb begin
      mux_we  = 1'b0;
      mux_sel = '0;
      mux_adr = '0;
      mux_dat = '0;
      g_idx   = '0;
      for (int i = 0; i < int'(c_N); i++) begin
         if (grant_q[i]) begin
            mux_we  = m_we_i[i];
            mux_sel = m_sel_i[i*c_WB_SEL_W +: c_WB_SEL_W];
            mux_adr = m_adr_i[i*c_WB_ADR_W +: c_WB_ADR_W];
            mux_dat = m_dat_i[i*c_WB_DAT_W +: c_WB_DAT_W];
            g_idx   = c_PTR_W'(i);
         end
      end
   end

   assign g_cyc     = |(m_cyc_i & grant_q);
   assign g_stb     = |(m_stb_i & grant_q);
   assign ptr_next  = (g_idx == c_LAST) ? '0 : g_idx + c_PTR_W'(1);
   assign cnt_full  = (cnt_q == c_CNT_W'(g_MAX_OUTSTANDING));
   assign wd_expire = (state_q != IDLE) && (cnt_q != '0) && !s_ack_i &&
                      (wdog_q == c_WD_W'(g_TIMEOUT - 1));

   assign s_we_o  = mux_we;
   assign s_sel_o = mux_sel;
   assign s_adr_o = mux_adr;
   assign s_dat_o = mux_dat;
   assign m_dat_o = s_dat_i;
   assign grant_o = grant_q;

   // FSM next state and bus-side handshake outputs.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      m_stall_o = '1;
      m_ack_o   = '0;
      timeout_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               grant_d = arb_gnt;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (wd_expire) begin
               // Abandon the hung slave; the master sees stall and must retry.
               timeout_o = 1'b1;
               state_d   = IDLE;
               grant_d   = '0;
               ptr_d     = ptr_next;
            end else if (!g_cyc && (cnt_q == '0)) begin
               m_ack_o = grant_q & {c_N{s_ack_i}};
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = ptr_next;
            end else begin
               s_cyc_o   = 1'b1;
               s_stb_o   = g_cyc & g_stb & ~cnt_full;
               m_stall_o = ~grant_q | {c_N{s_stall_i | cnt_full}};
               m_ack_o   = grant_q & {c_N{s_ack_i}};
               if (!g_cyc) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (wd_expire) begin
               timeout_o = 1'b1;
               state_d   = IDLE;
               grant_d   = '0;
               ptr_d     = ptr_next;
            end else begin
               // Keep CYC up through the final ack, drop it the cycle after.
               s_cyc_o = 1'b1;
               m_ack_o = grant_q & {c_N{s_ack_i}};
               if ((cnt_q == '0) || ((cnt_q == c_CNT_W'(1)) && s_ack_i)) begin
                  state_d = IDLE;
                  grant_d = '0;
                  ptr_d   = ptr_next;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Outstanding-strobe counter and no-ack watchdog.
   always_comb begin
      accept  = s_stb_o & ~s_stall_i;
      ack_dec = s_ack_i & (cnt_q != '0);
      cnt_d   = cnt_q;
      wdog_d  = wdog_q;
      if (wd_expire) begin
         cnt_d = '0;
      end else if (accept && !ack_dec) begin
         cnt_d = cnt_q + c_CNT_W'(1);
      end else if (!accept && ack_dec) begin
         cnt_d = cnt_q - c_CNT_W'(1);
      end
      if ((state_q == IDLE) || wd_expire || s_ack_i || (cnt_q == '0)) begin
         wdog_d = '0;
      end else begin
         wdog_d = wdog_q + c_WD_W'(1);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         wdog_q  <= wdog_d;
      end
   end

endmodule

// File: tb/tb_nic_dma_wb_arbiter.sv
// Bench for nic_dma_wb_arbiter: cycle table for arbitration/drain/reset,
// plus a slave model for data, outstanding limit and watchdog sequences.
module tb_nic_dma_wb_arbiter;

   localparam int MAXO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  m_cyc, m_stb, m_we;
   logic [7:0]  m_sel;
   logic [63:0] m_adr, m_dat;
   logic [31:0] m_dat_o;
   logic [1:0]  m_ack_o, m_stall_o, grant_o;
   logic        s_cyc_o, s_stb_o, s_we_o, timeout_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic        s_ack, s_stall, tb_ack;
   logic        mdl_en, mdl_ack;
   logic [31:0] mdl_dat;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign s_ack = mdl_en ? mdl_ack : tb_ack;

   nic_dma_wb_arbiter #(
      .g_NUM_MASTERS     (2),
      .g_MAX_OUTSTANDING (MAXO),
      .g_TIMEOUT         (16)
   ) dut (
      .clk_sys_i (clk),
      .rst_i     (rst),
      .m_cyc_i   (m_cyc),
      .m_stb_i   (m_stb),
      .m_we_i    (m_we),
      .m_sel_i   (m_sel),
      .m_adr_i   (m_adr),
      .m_dat_i   (m_dat),
      .m_dat_o   (m_dat_o),
      .m_ack_o   (m_ack_o),
      .m_stall_o (m_stall_o),
      .s_cyc_o   (s_cyc_o),
      .s_stb_o   (s_stb_o),
      .s_we_o    (s_we_o),
      .s_sel_o   (s_sel_o),
      .s_adr_o   (s_adr_o),
      .s_dat_o   (s_dat_o),
      .s_dat_i   (mdl_dat),
      .s_ack_i   (s_ack),
      .s_stall_i (s_stall),
      .grant_o   (grant_o),
      .timeout_o (timeout_o)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- slave model ----------------
   typedef struct {
      logic [31:0] dat;
      int          ready;
   } resp_t;
   resp_t       mdl_q[$];
   logic [31:0] mem [16];
   int          tick = 0;
   int          ack_delay = 1;
   int          log_n = 0;
   logic        log_we  [16];
   logic [31:0] log_adr [16];
   logic [31:0] log_dat [16];

   initial begin
      bit          acc_now, ack_now;
      logic        a_we;
      logic [31:0] a_adr, a_dat;
      resp_t       r;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      mdl_ack = 1'b0;
      mdl_dat = '0;
      forever begin
         @(negedge clk);
         acc_now = mdl_en && s_cyc_o && s_stb_o && !s_stall;
         ack_now = mdl_en && s_ack;
         a_we = s_we_o; a_adr = s_adr_o; a_dat = s_dat_o;
         @(posedge clk);
         #1;
         if (ack_now && mdl_q.size() != 0) mdl_q.delete(0);
         if (acc_now) begin
            if (log_n < 16) begin
               log_we[log_n] = a_we; log_adr[log_n] = a_adr; log_dat[log_n] = a_dat;
               log_n++;
            end
            r.dat = a_we ? 32'h0 : mem[a_adr[5:2]];
            r.ready = tick + ack_delay;
            if (a_we) mem[a_adr[5:2]] = a_dat;
            mdl_q.push_back(r);
         end
         tick++;
         mdl_ack = (mdl_q.size() != 0) && (mdl_q[0].ready <= tick);
         mdl_dat = (mdl_q.size() != 0) ? mdl_q[0].dat : 32'h0;
      end
   end

   // ---------------- master 0 driver ----------------
   logic        op_we  [8];
   logic [31:0] op_adr [8];
   logic [31:0] op_dat [8];
   logic [31:0] rd     [8];

   task automatic m0_run(input int n, output int acked, output int max_out,
                         output bit stall_ok, output logic [1:0] gnt_seen);
      int issued = 0;
      int cyc = 0;
      int outs;
      acked = 0; max_out = 0; stall_ok = 1'b1; gnt_seen = '0;
      m_cyc[0] = 1'b1;
      while (acked < n && cyc < 200) begin
         m_stb[0] = (issued < n);
         if (issued < n) begin
            m_we[0] = op_we[issued]; m_adr[31:0] = op_adr[issued]; m_dat[31:0] = op_dat[issued];
         end
         @(negedge clk);
         outs = issued - acked;
         if (outs > max_out) max_out = outs;
         if (outs == MAXO && !m_stall_o[0]) stall_ok = 1'b0;
         if (m_ack_o[0]) begin
            if (acked == 0) gnt_seen = grant_o;
            if (acked < 8) rd[acked] = m_dat_o;
            acked++;
         end
         if (m_stb[0] && !m_stall_o[0]) issued++;
         @(posedge clk);
         #1;
         cyc++;
      end
      m_cyc[0] = 1'b0;
      m_stb[0] = 1'b0;
   endtask

   // ---------------- cycle table ----------------
   typedef struct packed {
      logic       rst;
      logic [1:0] cyc, stb;
      logic       ack, stall;
      logic       scyc, sstb;
      logic [1:0] mstall, mack, gnt;
      logic       tmo;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic [1:0] c, input logic [1:0] s,
                               input logic a, input logic st, input logic sc,
                               input logic ss, input logic [1:0] ms, input logic [1:0] ma,
                               input logic [1:0] g, input logic t);
      vec_t v;
      v = '{rst: r, cyc: c, stb: s, ack: a, stall: st, scyc: sc, sstb: ss,
            mstall: ms, mack: ma, gnt: g, tmo: t};
      return v;
   endfunction

   vec_t tbl [24];

   initial begin
      int          acked, max_out, k, acc_cyc;
      bit          stall_ok, seen;
      logic [1:0]  gnt_seen;
      logic [31:0] exp_adr;

      //            rst cyc    stb    ack  stl  scyc sstb mstall mack   gnt    tmo
      tbl[0]  = mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0); // both ask, M0 wins
      tbl[1]  = mk(0, 2'b11, 2'b01, 0, 0, 1, 1, 2'b10, 2'b00, 2'b01, 0);
      tbl[2]  = mk(0, 2'b11, 2'b00, 1, 0, 1, 0, 2'b10, 2'b01, 2'b01, 0);
      tbl[3]  = mk(0, 2'b10, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 2'b01, 0); // M0 release
      tbl[4]  = mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0); // M0 re-asks, loses
      tbl[5]  = mk(0, 2'b11, 2'b10, 0, 1, 1, 1, 2'b11, 2'b00, 2'b10, 0); // slave stall
      tbl[6]  = mk(0, 2'b11, 2'b10, 0, 0, 1, 1, 2'b01, 2'b00, 2'b10, 0);
      tbl[7]  = mk(0, 2'b11, 2'b00, 1, 0, 1, 0, 2'b01, 2'b10, 2'b10, 0);
      tbl[8]  = mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 2'b10, 0); // M1 release
      tbl[9]  = mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
      tbl[10] = mk(0, 2'b01, 2'b01, 0, 0, 1, 1, 2'b10, 2'b00, 2'b01, 0);
      tbl[11] = mk(0, 2'b11, 2'b01, 0, 0, 1, 1, 2'b10, 2'b00, 2'b01, 0);
      tbl[12] = mk(0, 2'b10, 2'b00, 0, 0, 1, 0, 2'b10, 2'b00, 2'b01, 0); // drop, 2 pending
      tbl[13] = mk(0, 2'b10, 2'b00, 0, 0, 1, 0, 2'b11, 2'b00, 2'b01, 0); // drain
      tbl[14] = mk(0, 2'b10, 2'b00, 1, 0, 1, 0, 2'b11, 2'b01, 2'b01, 0);
      tbl[15] = mk(0, 2'b10, 2'b00, 1, 0, 1, 0, 2'b11, 2'b01, 2'b01, 0); // last ack
      tbl[16] = mk(0, 2'b10, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
      tbl[17] = mk(0, 2'b10, 2'b00, 0, 0, 1, 0, 2'b01, 2'b00, 2'b10, 0);
      tbl[18] = mk(0, 2'b10, 2'b10, 0, 0, 1, 1, 2'b01, 2'b00, 2'b10, 0);
      tbl[19] = mk(1, 2'b10, 2'b10, 0, 0, 1, 1, 2'b01, 2'b00, 2'b10, 0); // reset mid-burst
      tbl[20] = mk(0, 2'b10, 2'b10, 1, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0); // late ack dropped
      tbl[21] = mk(0, 2'b10, 2'b00, 0, 0, 1, 0, 2'b01, 2'b00, 2'b10, 0);
      tbl[22] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 2'b10, 0);
      tbl[23] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);

      rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; m_sel = 8'hFF;
      m_adr = {32'h200, 32'h100}; m_dat = '0; tb_ack = 1'b0; s_stall = 1'b0; mdl_en = 1'b0;

      // Reset state
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_s_cyc", 64'(s_cyc_o), 64'h0);
      chk("rst_s_stb", 64'(s_stb_o), 64'h0);
      chk("rst_m_stall", 64'(m_stall_o), 64'h3);
      chk("rst_m_ack", 64'(m_ack_o), 64'h0);
      chk("rst_grant", 64'(grant_o), 64'h0);
      chk("rst_timeout", 64'(timeout_o), 64'h0);
      @(posedge clk); #1;

      // Arbitration, drain and reset table
      for (int i = 0; i < 24; i++) begin
         rst = tbl[i].rst; m_cyc = tbl[i].cyc; m_stb = tbl[i].stb;
         tb_ack = tbl[i].ack; s_stall = tbl[i].stall;
         @(negedge clk);
         chk($sformatf("vec%0d", i),
             64'({s_cyc_o, s_stb_o, m_stall_o, m_ack_o, grant_o, timeout_o}),
             64'({tbl[i].scyc, tbl[i].sstb, tbl[i].mstall, tbl[i].mack, tbl[i].gnt, tbl[i].tmo}));
         if (tbl[i].sstb) begin
            exp_adr = (tbl[i].gnt == 2'b01) ? 32'h100 : 32'h200;
            chk($sformatf("vec%0d_adr", i), 64'(s_adr_o), 64'(exp_adr));
         end
         @(posedge clk); #1;
      end
      rst = 1'b0; m_cyc = '0; m_stb = '0; tb_ack = 1'b0; s_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Test 1: two writes, two reads through the slave model
      mdl_en = 1'b1; ack_delay = 1; log_n = 0;
      op_we[0] = 1'b1; op_adr[0] = 32'h0; op_dat[0] = 32'hDEADBEEF;
      op_we[1] = 1'b1; op_adr[1] = 32'h4; op_dat[1] = 32'hCAFEBABE;
      op_we[2] = 1'b0; op_adr[2] = 32'h0; op_dat[2] = 32'h0;
      op_we[3] = 1'b0; op_adr[3] = 32'h4; op_dat[3] = 32'h0;
      m0_run(4, acked, max_out, stall_ok, gnt_seen);
      chk("t1_acks", 64'(acked), 64'd4);
      chk("t1_slave_ops", 64'(log_n), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_op%0d_we", i), 64'(log_we[i]), 64'(op_we[i]));
         chk($sformatf("t1_op%0d_adr", i), 64'(log_adr[i]), 64'(op_adr[i]));
         if (op_we[i]) chk($sformatf("t1_op%0d_wdat", i), 64'(log_dat[i]), 64'(op_dat[i]));
      end
      chk("t1_rd0", 64'(rd[2]), 64'hDEADBEEF);
      chk("t1_rd1", 64'(rd[3]), 64'hCAFEBABE);
      chk("t1_grant", 64'(gnt_seen), 64'h1);
      repeat (3) @(posedge clk);
      #1;

      // Test 3: six back-to-back strobes against delayed acks
      ack_delay = 6; log_n = 0;
      for (int i = 0; i < 6; i++) begin
         op_we[i] = 1'b1; op_adr[i] = 32'(8 * i); op_dat[i] = 32'h1000 + 32'(i);
      end
      m0_run(6, acked, max_out, stall_ok, gnt_seen);
      chk("t3_acks", 64'(acked), 64'd6);
      chk("t3_max_outstanding", 64'(max_out), 64'd4);
      chk("t3_stall_when_full", 64'(stall_ok), 64'h1);
      chk("t3_slave_ops", 64'(log_n), 64'd6);
      repeat (3) @(posedge clk);
      #1;

      // Test 5: slave never acks, watchdog frees the port
      ack_delay = 1000;
      m_cyc = 2'b01; m_stb = 2'b01; m_we[0] = 1'b0; m_adr[31:0] = 32'h10;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (s_cyc_o && s_stb_o && !s_stall) seen = 1'b1;
         @(posedge clk); #1;
      end
      chk("t5_accepted", 64'(seen), 64'h1);
      m_stb = 2'b00; m_cyc = 2'b11;
      acc_cyc = -1;
      for (k = 1; k <= 30 && acc_cyc < 0; k++) begin
         @(negedge clk);
         if (timeout_o) begin
            acc_cyc = k;
            chk("t5_cyc_at_timeout", 64'(s_cyc_o), 64'h0);
            chk("t5_stall_at_timeout", 64'(m_stall_o[0]), 64'h1);
         end
         @(posedge clk); #1;
      end
      chk("t5_timeout_cycle", 64'(acc_cyc), 64'd16);
      m_cyc = 2'b10;
      @(negedge clk);
      chk("t5_pulse_width", 64'(timeout_o), 64'h0);
      chk("t5_idle_grant", 64'(grant_o), 64'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_grant_m1", 64'(grant_o), 64'h2);
      chk("t5_m1_cyc", 64'(s_cyc_o), 64'h1);
      @(posedge clk); #1;
      m_cyc = 2'b00;
      mdl_q.delete();
      repeat (3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
